// File: rtl/btn_event_ctrl.sv
// Button event controller: per-channel press/long/repeat FSMs sharing a 1 ms timebase,
// one pending slot per channel and a round-robin arbiter onto a valid/ready port.
module btn_event_ctrl #(
  parameter int unsigned P_CLK_HZ    = 100000000,
  parameter int unsigned P_NUM_BTN   = 4,
  parameter int unsigned P_LONG_MS   = 1000,
  parameter int unsigned P_REPEAT_MS = 200
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [P_NUM_BTN-1:0] iBtnLevel,
  input  logic                 iEvtReady,
  input  logic                 iClrOvf,
  output logic                 oEvtValid,
  output logic [2:0]           oEvtChan,
  output logic [1:0]           oEvtType,
  output logic [P_NUM_BTN-1:0] oOvf
);

  localparam int unsigned TickDiv = (P_CLK_HZ / 1000 > 0) ? P_CLK_HZ / 1000 : 1;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  localparam logic [1:0] EvtPress   = 2'd0;
  localparam logic [1:0] EvtRelease = 2'd1;
  localparam logic [1:0] EvtLong    = 2'd2;
  localparam logic [1:0] EvtRepeat  = 2'd3;

  typedef enum logic [1:0] {StIdle, StPress, StHold} stateE;

  stateE                stateQ   [P_NUM_BTN];
  stateE                stateD   [P_NUM_BTN];
  logic [15:0]          msCntQ   [P_NUM_BTN];
  logic [15:0]          msCntD   [P_NUM_BTN];
  logic [1:0]           newType  [P_NUM_BTN];
  logic [1:0]           slotTypeQ[P_NUM_BTN];
  logic [1:0]           slotTypeD[P_NUM_BTN];
  logic [P_NUM_BTN-1:0] prevQ, riseVec, fallVec, evtNew;
  logic [P_NUM_BTN-1:0] slotValidQ, slotValidD, grantVec, ovfQ, ovfD, ovfSet;
  logic [TickW-1:0]     tickCntQ;
  logic                 msTick;

  logic                 evtValidQ, load, found;
  logic [2:0]           evtChanQ, winIdx, rrPtrQ;
  logic [1:0]           evtTypeQ, winType;

  assign msTick  = (tickCntQ == TickW'(TickDiv - 1));
  assign riseVec = iBtnLevel & ~prevQ;
  assign fallVec = ~iBtnLevel & prevQ;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tickCntQ <= '0;
      prevQ    <= '0;
    end else begin
      tickCntQ <= msTick ? '0 : tickCntQ + TickW'(1);
      prevQ    <= iBtnLevel;
    end
  end

  // Per-channel FSM; a release always beats a timer expiry in the same cycle.
  always_comb begin
    for (int i = 0; i < P_NUM_BTN; i++) begin
      stateD[i]  = stateQ[i];
      msCntD[i]  = msCntQ[i];
      evtNew[i]  = 1'b0;
      newType[i] = EvtPress;
      case (stateQ[i])
        StIdle: begin
          if (riseVec[i]) begin
            evtNew[i]  = 1'b1;
            newType[i] = EvtPress;
            msCntD[i]  = '0;
            stateD[i]  = StPress;
          end
        end
        StPress: begin
          if (fallVec[i]) begin
            evtNew[i]  = 1'b1;
            newType[i] = EvtRelease;
            stateD[i]  = StIdle;
          end else if (msTick) begin
            if (msCntQ[i] + 16'd1 == 16'(P_LONG_MS)) begin
              evtNew[i]  = 1'b1;
              newType[i] = EvtLong;
              msCntD[i]  = '0;
              stateD[i]  = StHold;
            end else begin
              msCntD[i] = msCntQ[i] + 16'd1;
            end
          end
        end
        StHold: begin
          if (fallVec[i]) begin
            evtNew[i]  = 1'b1;
            newType[i] = EvtRelease;
            stateD[i]  = StIdle;
          end else if (P_REPEAT_MS != 0 && msTick) begin
            if (msCntQ[i] + 16'd1 == 16'(P_REPEAT_MS)) begin
              evtNew[i]  = 1'b1;
              newType[i] = EvtRepeat;
              msCntD[i]  = '0;
            end else begin
              msCntD[i] = msCntQ[i] + 16'd1;
            end
          end
        end
        default: stateD[i] = StIdle;
      endcase
    end
  end

  // Round-robin pick: first valid slot at or after the pointer, wrapping.
  always_comb begin
    load    = ~evtValidQ | iEvtReady;
    found   = 1'b0;
    winIdx  = '0;
    winType = EvtPress;
    for (int k = 0; k < P_NUM_BTN; k++) begin
      for (int j = 0; j < P_NUM_BTN; j++) begin
        if (!found && slotValidQ[j] && ((int'(rrPtrQ) + k) % int'(P_NUM_BTN) == j)) begin
          found   = 1'b1;
          winIdx  = 3'(j);
          winType = slotTypeQ[j];
        end
      end
    end
    for (int i = 0; i < P_NUM_BTN; i++) begin
      grantVec[i] = load && found && (winIdx == 3'(i));
    end
  end

  // Newest event wins a full slot; overflow only if the old entry was not granted.
  always_comb begin
    for (int i = 0; i < P_NUM_BTN; i++) begin
      slotValidD[i] = slotValidQ[i] & ~grantVec[i];
      slotTypeD[i]  = slotTypeQ[i];
      ovfSet[i]     = 1'b0;
      if (evtNew[i]) begin
        slotValidD[i] = 1'b1;
        slotTypeD[i]  = newType[i];
        ovfSet[i]     = slotValidQ[i] & ~grantVec[i];
      end
    end
    ovfD = iClrOvf ? '0 : (ovfQ | ovfSet);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < P_NUM_BTN; i++) begin
        stateQ[i]    <= StIdle;
        msCntQ[i]    <= '0;
        slotTypeQ[i] <= EvtPress;
      end
      slotValidQ <= '0;
      ovfQ       <= '0;
      evtValidQ  <= 1'b0;
      evtChanQ   <= '0;
      evtTypeQ   <= EvtPress;
      rrPtrQ     <= '0;
    end else begin
      for (int i = 0; i < P_NUM_BTN; i++) begin
        stateQ[i]    <= stateD[i];
        msCntQ[i]    <= msCntD[i];
        slotTypeQ[i] <= slotTypeD[i];
      end
      slotValidQ <= slotValidD;
      ovfQ       <= ovfD;
      if (load) begin
        evtValidQ <= found;
        if (found) begin
          evtChanQ <= winIdx;
          evtTypeQ <= winType;
          rrPtrQ   <= (winIdx == 3'(P_NUM_BTN - 1)) ? 3'd0 : winIdx + 3'd1;
        end
      end
    end
  end

  assign oEvtValid = evtValidQ;
  assign oEvtChan  = evtChanQ;
  assign oEvtType  = evtTypeQ;
  assign oOvf      = ovfQ;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: 10-clock ms tick, LONG=5 ms, REPEAT=3 ms, 4 channels,
// plus a second instance with REPEAT disabled.
module tb_btn_event_ctrl;

  localparam int EvPress = 0, EvRel = 1, EvLong = 2, EvRep = 3;

  typedef struct {
    int chan;
    int typ;
    int cyc;
  } evT;

  logic       clk, rst, evtReady, clrOvf;
  logic [3:0] btn, btn2, ovf, ovf2;
  logic       evtValid, valid2;
  logic [2:0] evtChan, chan2;
  logic [1:0] evtType, type2;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;
  int c0, c1, p, r, a, b, s, u, ld;
  evT evQ[$];
  evT ev2Q[$];

  btn_event_ctrl #(
    .P_CLK_HZ(10000), .P_NUM_BTN(4), .P_LONG_MS(5), .P_REPEAT_MS(3)
  ) dut (
    .iClk(clk), .iRst(rst), .iBtnLevel(btn), .iEvtReady(evtReady), .iClrOvf(clrOvf),
    .oEvtValid(evtValid), .oEvtChan(evtChan), .oEvtType(evtType), .oOvf(ovf)
  );

  btn_event_ctrl #(
    .P_CLK_HZ(10000), .P_NUM_BTN(4), .P_LONG_MS(5), .P_REPEAT_MS(0)
  ) dutNoRep (
    .iClk(clk), .iRst(rst), .iBtnLevel(btn2), .iEvtReady(1'b1), .iClrOvf(1'b0),
    .oEvtValid(valid2), .oEvtChan(chan2), .oEvtType(type2), .oOvf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst && evtValid && evtReady)
      evQ.push_back('{chan: int'(evtChan), typ: int'(evtType), cyc: cyc});
    if (!rst && valid2)
      ev2Q.push_back('{chan: int'(chan2), typ: int'(type2), cyc: cyc});
  end

  task automatic checkEq(input string tag, input int obs, input int exp);
    nCmp++;
    if (obs != exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expEv(input string tag, input int idx, input int ch, input int ty,
                       input int cy);
    if (idx < evQ.size()) begin
      checkEq({tag, "_chan"}, evQ[idx].chan, ch);
      checkEq({tag, "_type"}, evQ[idx].typ, ty);
      checkEq({tag, "_cyc"}, evQ[idx].cyc, cy);
    end else begin
      checkEq({tag, "_present"}, evQ.size(), idx + 1);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(3);
  endtask

  initial begin
    rst = 1'b1; btn = '0; btn2 = '0; evtReady = 1'b1; clrOvf = 1'b0;
    waitCycles(3);
    checkEq("rst_valid", int'(evtValid), 0);
    checkEq("rst_chan", int'(evtChan), 0);
    checkEq("rst_type", int'(evtType), 0);
    checkEq("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    waitCycles(5);

    // 1: single press/release on ch0, two-cycle latency, one cycle each
    evQ.delete();
    c0 = cyc; btn = 4'b0001; waitCycles(6);
    c1 = cyc; btn = 4'b0000; waitCycles(6);
    checkEq("t1_count", evQ.size(), 2);
    expEv("t1_press", 0, 0, EvPress, c0 + 2);
    expEv("t1_rel", 1, 0, EvRel, c1 + 2);

    // 2: ch1 held 120 clocks -> PRESS, LONG, REPEAT x2, RELEASE
    evQ.delete();
    p = cyc; btn = 4'b0010; waitCycles(120);
    btn = 4'b0000; waitCycles(60);
    checkEq("t2_count", evQ.size(), 5);
    if (evQ.size() == 5) begin
      expEv("t2_press", 0, 1, EvPress, p + 2);
      checkEq("t2_long_type", evQ[1].typ, EvLong);
      checkEq("t2_long_chan", evQ[1].chan, 1);
      ld = evQ[1].cyc - (p + 2);
      checkEq("t2_long_window", int'(ld >= 41 && ld <= 50), 1);
      checkEq("t2_rep1_type", evQ[2].typ, EvRep);
      checkEq("t2_rep1_gap", evQ[2].cyc - evQ[1].cyc, 30);
      checkEq("t2_rep2_type", evQ[3].typ, EvRep);
      checkEq("t2_rep2_gap", evQ[3].cyc - evQ[2].cyc, 30);
      expEv("t2_rel", 4, 1, EvRel, p + 122);
    end

    // 3: simultaneous presses, round-robin from pointer 0 then from pointer 2
    doReset();
    evQ.delete();
    r = cyc; btn = 4'b1111; waitCycles(10);
    btn = 4'b0000; waitCycles(10);
    btn = 4'b0010; waitCycles(5);
    btn = 4'b0000; waitCycles(5);
    btn = 4'b1111; waitCycles(10);
    btn = 4'b0000; waitCycles(10);
    checkEq("t3_count", evQ.size(), 18);
    for (int i = 0; i < 4; i++) expEv($sformatf("t3_a%0d", i), i, i, EvPress, r + 2 + i);
    for (int i = 0; i < 4; i++)
      expEv($sformatf("t3_b%0d", i), 10 + i, (i + 2) % 4, EvPress, r + 32 + i);

    // 4: backpressure, queued RELEASE, then overflow and clear
    doReset();
    evtReady = 1'b0;
    a = cyc; btn = 4'b0100; waitCycles(3);
    checkEq("t4_hold1_valid", int'(evtValid), 1);
    checkEq("t4_hold1_chan", int'(evtChan), 2);
    checkEq("t4_hold1_type", int'(evtType), EvPress);
    waitCycles(2);
    btn = 4'b0000; waitCycles(3);
    checkEq("t4_hold2_chan", int'(evtChan), 2);
    checkEq("t4_hold2_type", int'(evtType), EvPress);
    checkEq("t4_noovf", int'(ovf), 0);
    evQ.delete();
    evtReady = 1'b1; waitCycles(4);
    checkEq("t4_drain_count", evQ.size(), 2);
    expEv("t4_press", 0, 2, EvPress, a + 8);
    expEv("t4_rel", 1, 2, EvRel, a + 9);
    checkEq("t4_noovf2", int'(ovf), 0);

    evtReady = 1'b0;
    b = cyc; btn = 4'b0100; waitCycles(4);
    btn = 4'b0000; waitCycles(4);
    btn = 4'b0100; waitCycles(2);
    checkEq("t4_ovf_set", int'(ovf), 4);
    checkEq("t4_ovf_out_type", int'(evtType), EvPress);
    clrOvf = 1'b1; waitCycles(1);
    clrOvf = 1'b0;
    checkEq("t4_ovf_clr", int'(ovf), 0);
    evQ.delete();
    evtReady = 1'b1; waitCycles(3);
    btn = 4'b0000; waitCycles(5);
    checkEq("t4_ovf_count", evQ.size(), 3);
    expEv("t4_o0", 0, 2, EvPress, b + 11);
    expEv("t4_o1", 1, 2, EvPress, b + 12);
    expEv("t4_o2", 2, 2, EvRel, b + 16);

    // 5: repeat disabled -> PRESS, LONG, RELEASE only
    ev2Q.delete();
    s = cyc; btn2 = 4'b0001; waitCycles(200);
    btn2 = 4'b0000; waitCycles(60);
    checkEq("t5_count", ev2Q.size(), 3);
    if (ev2Q.size() == 3) begin
      checkEq("t5_press_type", ev2Q[0].typ, EvPress);
      checkEq("t5_press_cyc", ev2Q[0].cyc, s + 2);
      checkEq("t5_long_type", ev2Q[1].typ, EvLong);
      checkEq("t5_rel_type", ev2Q[2].typ, EvRel);
      checkEq("t5_rel_cyc", ev2Q[2].cyc, s + 202);
    end

    // 6: async reset with pending events, ch0 held high across reset release
    evtReady = 1'b0;
    btn = 4'b0001; waitCycles(4);
    btn = 4'b0000; waitCycles(3);
    checkEq("t6_pre_valid", int'(evtValid), 1);
    #2;
    rst = 1'b1;
    btn = 4'b0001;
    #1;
    checkEq("t6_async_valid", int'(evtValid), 0);
    checkEq("t6_async_chan", int'(evtChan), 0);
    waitCycles(2);
    evQ.delete();
    evtReady = 1'b1;
    u = cyc;
    rst = 1'b0;
    waitCycles(20);
    checkEq("t6_count", evQ.size(), 1);
    expEv("t6_press", 0, 0, EvPress, u + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
